// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO read-side stream adapter.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order skid buffer that absorbs the FIFO read latency.
module rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic [1:0]    occ_o
);

    localparam int PW = $clog2(SKID_DEPTH);

    logic [DW-1:0] mem_q [SKID_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [1:0]    occ_q;
    logic [1:0]    occ_d;

    always_comb begin
        occ_d = occ_q;
        if (push_i && !pop_i) begin
            occ_d = occ_q + 2'd1;
        end else if (pop_i && !push_i) begin
            occ_d = occ_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            occ_q <= occ_d;
        end
    end

    assign data_o = mem_q[rd_ptr_q];
    assign occ_o  = occ_q;

    // The read-issue throttle upstream must make both of these impossible.
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(push_i && !pop_i && (occ_q == 2'(SKID_DEPTH))));
    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(pop_i && (occ_q == 2'd0)));

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops the byte FIFO and presents its data on a valid/ready stream,
// hiding the registered read latency and the write-over-read priority.
//
//   state | meaning
//   IDLE  | disabled, nothing buffered or in flight
//   RUN   | FIFO reads issued while there is room
//   DRAIN | no new reads; in-flight and buffered bytes still delivered
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DW   = 8,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            fifo_empty_i,
    input  logic            fifo_full_i,
    input  logic            fifo_wr_i,
    input  logic [DW-1:0]   fifo_dout_i,
    output logic            fifo_rd_o,
    output logic [DW-1:0]   m_data_o,
    output logic            m_valid_o,
    input  logic            m_ready_i,
    output logic            busy_o,
    output logic [CNTW-1:0] pop_cnt_o
);

    rd_state_e       state_q, state_d;
    logic            pend_q, pend_d;
    logic [CNTW-1:0] pop_cnt_q, pop_cnt_d;
    logic [1:0]      occ;
    logic [2:0]      inflight;
    logic            out_pop;
    logic            accept;

    assign out_pop  = m_valid_o && m_ready_i;
    assign inflight = 3'(occ) + 3'(pend_q) - 3'(out_pop);

    // A write that lands in the same cycle wins the FIFO; such a read is retried.
    assign fifo_rd_o = !rst_i && (state_q == RUN) && !fifo_empty_i
                       && (inflight < 3'(SKID_DEPTH));
    assign accept    = fifo_rd_o && !fifo_empty_i && !(fifo_wr_i && !fifo_full_i);

    always_comb begin
        state_d   = state_q;
        pend_d    = accept;
        pop_cnt_d = pop_cnt_q + CNTW'(accept);
        unique case (state_q)
            IDLE: begin
                if (en_i) state_d = RUN;
            end
            RUN: begin
                if (!en_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (en_i) begin
                    state_d = RUN;
                end else if ((occ == 2'd0) && !pend_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pend_q    <= 1'b0;
            pop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            pop_cnt_q <= pop_cnt_d;
        end
    end

    rd_skid_buf #(
        .DW (DW)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (pend_q),
        .data_i (fifo_dout_i),
        .pop_i  (out_pop),
        .data_o (m_data_o),
        .occ_o  (occ)
    );

    assign m_valid_o = (occ != 2'd0);
    assign busy_o    = (state_q != IDLE);
    assign pop_cnt_o = pop_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: a behavioural 16-entry FIFO feeds two readers (CNTW=16 and CNTW=4).
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, wr, m_ready;
    logic [7:0]  wdata;
    logic        fifo_empty, fifo_full;
    logic [7:0]  fifo_dout;

    logic        fifo_rd, m_valid, busy;
    logic [7:0]  m_data;
    logic [15:0] m_cnt;
    logic        s_rd, s_valid, s_busy;
    logic [7:0]  s_data;
    logic [3:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;

    fifo_stream_reader #(.DW(8), .CNTW(16)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full), .fifo_wr_i(wr),
        .fifo_dout_i(fifo_dout), .fifo_rd_o(fifo_rd),
        .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .busy_o(busy), .pop_cnt_o(m_cnt)
    );

    fifo_stream_reader #(.DW(8), .CNTW(4)) dut_small (
        .clk_i(clk), .rst_i(rst), .en_i(en),
        .fifo_empty_i(fifo_empty), .fifo_full_i(fifo_full), .fifo_wr_i(wr),
        .fifo_dout_i(fifo_dout), .fifo_rd_o(s_rd),
        .m_data_o(s_data), .m_valid_o(s_valid), .m_ready_i(m_ready),
        .busy_o(s_busy), .pop_cnt_o(s_cnt)
    );

    // Behavioural FIFO: registered dout, write takes priority over read.
    logic [7:0] fmem [16];
    logic [3:0] fhead, ftail;
    logic [4:0] fcount;
    assign fifo_empty = (fcount == 5'd0);
    assign fifo_full  = (fcount == 5'd16);

    always @(posedge clk) begin
        if (rst) begin
            fhead <= '0; ftail <= '0; fcount <= '0; fifo_dout <= '0;
        end else if (wr && !fifo_full) begin
            fmem[ftail] <= wdata; ftail <= ftail + 4'd1; fcount <= fcount + 5'd1;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_dout <= fmem[fhead]; fhead <= fhead + 4'd1; fcount <= fcount - 5'd1;
        end
    end

    typedef struct {
        logic        rst, en, wr;
        logic [7:0]  wd;
        logic        rdy;
        logic        rd, val, chkd;
        logic [7:0]  data;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vq[$];

    function automatic void v(input logic r, e, w, input logic [7:0] wd, input logic rdy,
                              input logic xrd, xval, xchk, input logic [7:0] xdata,
                              input logic xbusy, input logic [15:0] xcnt);
        vec_t t;
        t.rst = r; t.en = e; t.wr = w; t.wd = wd; t.rdy = rdy;
        t.rd = xrd; t.val = xval; t.chkd = xchk; t.data = xdata; t.busy = xbusy; t.cnt = xcnt;
        vq.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic run_vectors(input string grp);
        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst; en = vq[i].en; wr = vq[i].wr; wdata = vq[i].wd; m_ready = vq[i].rdy;
            #1;
            n_vec++;
            if (fifo_rd !== vq[i].rd || s_rd !== vq[i].rd) begin
                n_err++;
                $display("FAIL %s[%0d] fifo_rd: got %b/%b expected %b", grp, i, fifo_rd, s_rd, vq[i].rd);
            end
            if (m_valid !== vq[i].val || s_valid !== vq[i].val) begin
                n_err++;
                $display("FAIL %s[%0d] m_valid: got %b/%b expected %b", grp, i, m_valid, s_valid, vq[i].val);
            end
            if (vq[i].chkd && (m_data !== vq[i].data || s_data !== vq[i].data)) begin
                n_err++;
                $display("FAIL %s[%0d] m_data: got %h/%h expected %h", grp, i, m_data, s_data, vq[i].data);
            end
            if (busy !== vq[i].busy || s_busy !== vq[i].busy) begin
                n_err++;
                $display("FAIL %s[%0d] busy: got %b/%b expected %b", grp, i, busy, s_busy, vq[i].busy);
            end
            if (m_cnt !== vq[i].cnt || s_cnt !== vq[i].cnt[3:0]) begin
                n_err++;
                $display("FAIL %s[%0d] pop_cnt: got %0d/%0d expected %0d", grp, i, m_cnt, s_cnt, vq[i].cnt);
            end
        end
        vq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx [17];
        logic [7:0] exp_b;
        int  got_n;
        bit  sent;

        rst = 1'b1; en = 1'b0; wr = 1'b0; wdata = '0; m_ready = 1'b1;
        repeat (2) @(posedge clk);

        // reset state
        v(1,0,0,8'h00,1, 0,0,1,8'h00,0,0);
        run_vectors("reset");

        // basic stream 11,22,33
        v(0,0,1,8'h11,1, 0,0,0,8'h00,0,0);
        v(0,0,1,8'h22,1, 0,0,0,8'h00,0,0);
        v(0,0,1,8'h33,1, 0,0,0,8'h00,0,0);
        v(0,1,0,8'h00,1, 0,0,0,8'h00,0,0);
        v(0,1,0,8'h00,1, 1,0,0,8'h00,1,0);
        v(0,1,0,8'h00,1, 1,0,0,8'h00,1,1);
        v(0,1,0,8'h00,1, 1,1,1,8'h11,1,2);
        v(0,1,0,8'h00,1, 0,1,1,8'h22,1,3);
        v(0,1,0,8'h00,1, 0,1,1,8'h33,1,3);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,1,3);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,1,3);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,0,3);
        run_vectors("basic");
        check("basic_fifo_empty", 32'(fifo_empty), 32'd1);

        // write collision on the first read cycle delays A5 by one cycle
        v(0,0,1,8'hA5,1, 0,0,0,8'h00,0,3);
        v(0,1,0,8'h00,1, 0,0,0,8'h00,0,3);
        v(0,1,1,8'h5A,1, 1,0,0,8'h00,1,3);
        v(0,1,0,8'h00,1, 1,0,0,8'h00,1,3);
        v(0,1,0,8'h00,1, 1,0,0,8'h00,1,4);
        v(0,1,0,8'h00,1, 0,1,1,8'hA5,1,5);
        v(0,0,0,8'h00,1, 0,1,1,8'h5A,1,5);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,1,5);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,0,5);
        run_vectors("collision");

        // backpressure: ten cycles of m_ready=0 allow exactly two pops
        for (int i = 1; i <= 5; i++) v(0,0,1,8'(i),0, 0,0,0,8'h00,0,5);
        v(0,1,0,8'h00,0, 0,0,0,8'h00,0,5);
        v(0,1,0,8'h00,0, 1,0,0,8'h00,1,5);
        v(0,1,0,8'h00,0, 1,0,0,8'h00,1,6);
        for (int i = 0; i < 7; i++) v(0,1,0,8'h00,0, 0,1,1,8'h01,1,7);
        v(0,1,0,8'h00,1, 1,1,1,8'h01,1,7);
        v(0,1,0,8'h00,1, 1,1,1,8'h02,1,8);
        v(0,1,0,8'h00,1, 1,1,1,8'h03,1,9);
        v(0,1,0,8'h00,1, 0,1,1,8'h04,1,10);
        v(0,0,0,8'h00,1, 0,1,1,8'h05,1,10);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,1,10);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,0,10);
        run_vectors("backpressure");

        // drain: en drops as the first pop is accepted
        v(0,0,1,8'h71,1, 0,0,0,8'h00,0,10);
        v(0,0,1,8'h72,1, 0,0,0,8'h00,0,10);
        v(0,0,1,8'h73,1, 0,0,0,8'h00,0,10);
        v(0,1,0,8'h00,1, 0,0,0,8'h00,0,10);
        v(0,0,0,8'h00,1, 1,0,0,8'h00,1,10);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,1,11);
        v(0,0,0,8'h00,1, 0,1,1,8'h71,1,11);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,1,11);
        v(0,0,0,8'h00,1, 0,0,0,8'h00,0,11);
        run_vectors("drain");
        check("drain_fifo_left", 32'(fcount), 32'd2);

        // reset with the skid buffer full; rst must also mask fifo_rd
        v(0,0,1,8'h74,0, 0,0,0,8'h00,0,11);
        v(0,0,1,8'h75,0, 0,0,0,8'h00,0,11);
        v(0,0,1,8'h76,0, 0,0,0,8'h00,0,11);
        v(0,1,0,8'h00,0, 0,0,0,8'h00,0,11);
        v(0,1,0,8'h00,0, 1,0,0,8'h00,1,11);
        v(0,1,0,8'h00,0, 1,0,0,8'h00,1,12);
        v(0,1,0,8'h00,0, 0,1,1,8'h72,1,13);
        v(1,1,0,8'h00,1, 0,1,1,8'h72,1,13);
        v(0,0,0,8'h00,1, 0,0,1,8'h00,0,0);
        run_vectors("midreset");

        // counter wrap: 17 bytes, refilling once the FIFO has room
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = 1'b0; en = 1'b0; wr = 1'b1; wdata = 8'h80 + 8'(i); m_ready = 1'b1;
        end
        @(negedge clk);
        wr = 1'b0; en = 1'b1;
        got_n = 0;
        sent  = 1'b0;
        for (int c = 0; c < 200 && got_n < 17; c++) begin
            @(negedge clk);
            if (!sent && !fifo_full) begin
                wr = 1'b1; wdata = 8'hC0; sent = 1'b1;
            end else begin
                wr = 1'b0;
            end
            #1;
            if (m_valid && m_ready) begin
                rx[got_n] = m_data;
                got_n++;
            end
        end
        wr = 1'b0;
        check("wrap_byte_count", 32'(got_n), 32'd17);
        for (int i = 0; i < got_n; i++) begin
            exp_b = (i < 16) ? 8'h80 + 8'(i) : 8'hC0;
            check($sformatf("wrap_data[%0d]", i), 32'(rx[i]), 32'(exp_b));
        end
        check("wrap_pop_cnt_w16", 32'(m_cnt), 32'd17);
        check("wrap_pop_cnt_w4", 32'(s_cnt), 32'd1);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("wrap_busy_after", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
